// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if
//   Groups the fetch handshake and the pipeline-control signals that pass
//   between hazard_ctrl and the IF/ID, ID/EX, PC and instruction-memory side.
//
//   Fetch handshake: imem_req is a level request; a transfer completes on a
//   posedge where imem_req and imem_ack are both high. The requester may drop
//   imem_req before an ack arrives, which abandons the outstanding fetch.
//
//   Signals (direction as seen by the controller, modport master):
//     imem_req      out  fetch request
//     imem_ack      in   instruction memory has valid data this cycle
//     ifid_rs/rt    in   source register fields of the instruction in IF/ID
//     ifid_uses_rs  in   IF/ID instruction reads rs
//     ifid_uses_rt  in   IF/ID instruction reads rt
//     idex_mem_read in   instruction in ID/EX is a load
//     idex_rd       in   destination register of the instruction in ID/EX
//     branch_taken  in   taken branch/jump resolved in EX this cycle
//     pc_we         out  PC loads its next value
//     ifid_we       out  IF/ID captures fetched PC and instruction
//     ifid_flush    out  IF/ID loads a NOP (wins over ifid_we)
//     idex_bubble   out  ID/EX loads a NOP
//   modport slave is the mirror image, used by the pipeline/testbench side.
interface hazard_ctrl_if #(
    parameter int REG_ADDR_W = 6
);
    logic                  imem_req;
    logic                  imem_ack;
    logic [REG_ADDR_W-1:0] ifid_rs;
    logic [REG_ADDR_W-1:0] ifid_rt;
    logic                  ifid_uses_rs;
    logic                  ifid_uses_rt;
    logic                  idex_mem_read;
    logic [REG_ADDR_W-1:0] idex_rd;
    logic                  branch_taken;
    logic                  pc_we;
    logic                  ifid_we;
    logic                  ifid_flush;
    logic                  idex_bubble;

    modport master (
        output imem_req, pc_we, ifid_we, ifid_flush, idex_bubble,
        input  imem_ack, ifid_rs, ifid_rt, ifid_uses_rs, ifid_uses_rt,
               idex_mem_read, idex_rd, branch_taken
    );

    modport slave (
        input  imem_req, pc_we, ifid_we, ifid_flush, idex_bubble,
        output imem_ack, ifid_rs, ifid_rt, ifid_uses_rs, ifid_uses_rt,
               idex_mem_read, idex_rd, branch_taken
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline sequencing controller for the IF stage and the IF/ID buffer.
//   Issues instruction-fetch requests, drives the PC write enable, the IF/ID
//   write enable / flush and the ID/EX bubble from branch, load-use and
//   fetch-wait conditions.
//
//   Ports:
//     clk        in   clock, all state updates on posedge
//     rst        in   asynchronous active-high reset
//     bus        hazard_ctrl_if.master  fetch handshake + pipeline controls
//     state      out  [1:0]  current FSM state (BOOT=0 RUN=1 WAIT_MEM=2 FLUSH=3)
//     stall_cnt  out  [15:0] stall-cycle performance counter
//
//   Parameters:
//     REG_ADDR_W    register-specifier width
//     FLUSH_CYCLES  squash cycles after a taken branch, legal 1..15
//
//   Optional feature macro: HAZARD_PERF_CNT_EN
//     defined   - stall_cnt counts posedges with state != BOOT and pc_we == 0,
//                 saturating at 16'hFFFF, cleared only by rst
//     undefined - stall_cnt is tied to 0 and no counter register exists
//
//   state and the squash counter are registered; all other control outputs
//   are combinational from state and the current inputs.
module hazard_ctrl #(
    parameter int REG_ADDR_W   = 6,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_ctrl_if.master        bus,
    output logic [1:0]           state,
    output logic [15:0]          stall_cnt
);

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        WAIT_MEM = 2'd2,
        FLUSH    = 2'd3
    } state_t;

    // The branch cycle itself is the first squash cycle, so FLUSH needs
    // FLUSH_CYCLES-1 more cycles; fcnt counts down to 0 inclusive.
    localparam logic [3:0] FCNT_INIT = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;
    localparam bit         USE_FLUSH = (FLUSH_CYCLES > 1);

    state_t                state_q;
    logic [3:0]            fcnt;
    logic                  luh;
    logic [REG_ADDR_W-1:0] ld_rd;

    assign ld_rd = bus.idex_rd;
    assign state = state_q;

    // Load-use hazard: a load in ID/EX writes a register (not r0) that the
    // instruction in IF/ID reads.
    always_comb begin
        luh = 1'b0;
        if (bus.idex_mem_read && (ld_rd != '0)) begin
            luh = (bus.ifid_uses_rs && (bus.ifid_rs == ld_rd)) ||
                  (bus.ifid_uses_rt && (bus.ifid_rt == ld_rd));
        end
    end

    // Mealy control outputs.
    always_comb begin
        bus.imem_req    = 1'b0;
        bus.pc_we       = 1'b0;
        bus.ifid_we     = 1'b0;
        bus.ifid_flush  = 1'b0;
        bus.idex_bubble = 1'b0;
        unique case (state_q)
            BOOT: begin
            end
            RUN: begin
                if (bus.branch_taken) begin
                    bus.pc_we       = 1'b1;
                    bus.ifid_flush  = 1'b1;
                    bus.idex_bubble = 1'b1;
                end else if (luh) begin
                    bus.imem_req    = 1'b1;
                    bus.idex_bubble = 1'b1;
                end else if (!bus.imem_ack) begin
                    bus.imem_req    = 1'b1;
                    bus.ifid_flush  = 1'b1;
                end else begin
                    bus.imem_req    = 1'b1;
                    bus.pc_we       = 1'b1;
                    bus.ifid_we     = 1'b1;
                end
            end
            WAIT_MEM: begin
                // IF/ID holds a NOP here, so the load-use check is irrelevant.
                if (bus.branch_taken) begin
                    bus.pc_we       = 1'b1;
                    bus.ifid_flush  = 1'b1;
                    bus.idex_bubble = 1'b1;
                end else if (bus.imem_ack) begin
                    bus.imem_req    = 1'b1;
                    bus.pc_we       = 1'b1;
                    bus.ifid_we     = 1'b1;
                end else begin
                    bus.imem_req    = 1'b1;
                    bus.ifid_flush  = 1'b1;
                end
            end
            FLUSH: begin
                // Only NOPs occupy EX, so branch_taken cannot be genuine here.
                bus.ifid_flush  = 1'b1;
                bus.idex_bubble = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // State register and squash counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            fcnt    <= 4'd0;
        end else begin
            unique case (state_q)
                BOOT: begin
                    state_q <= RUN;
                end
                RUN: begin
                    if (bus.branch_taken) begin
                        if (USE_FLUSH) begin
                            state_q <= FLUSH;
                            fcnt    <= FCNT_INIT;
                        end
                    end else if (luh) begin
                        state_q <= RUN;
                    end else if (!bus.imem_ack) begin
                        state_q <= WAIT_MEM;
                    end
                end
                WAIT_MEM: begin
                    if (bus.branch_taken) begin
                        if (USE_FLUSH) begin
                            state_q <= FLUSH;
                            fcnt    <= FCNT_INIT;
                        end else begin
                            state_q <= RUN;
                        end
                    end else if (bus.imem_ack) begin
                        state_q <= RUN;
                    end
                end
                FLUSH: begin
                    if (fcnt == 4'd0) begin
                        state_q <= RUN;
                    end else begin
                        fcnt <= fcnt - 4'd1;
                    end
                end
                default: begin
                    state_q <= BOOT;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 16'd0;
        end else if ((state_q != BOOT) && !bus.pc_we && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign stall_cnt = cnt_q;
`else
    assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int FLUSH_CYCLES = 3;
`ifdef HAZARD_PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  localparam int F_STATE = 0;
  localparam int F_REQ   = 1;
  localparam int F_PC    = 2;
  localparam int F_WE    = 3;
  localparam int F_FLUSH = 4;
  localparam int F_BUB   = 5;
  localparam int F_CNT   = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic [1:0]  state;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_ADDR_W(6)) bus ();

  hazard_ctrl #(
    .REG_ADDR_W  (6),
    .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .state    (state),
    .stall_cnt(stall_cnt)
  );

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Hand-computed expectations, keyed by the negedge number they apply to.
  logic [15:0] exp_q[$];
  int          lit_cyc[$];
  int          lit_sel[$];
  int          lit_idx = 0;

  function automatic string fname(input int sel);
    case (sel)
      F_STATE: return "state";
      F_REQ:   return "imem_req";
      F_PC:    return "pc_we";
      F_WE:    return "ifid_we";
      F_FLUSH: return "ifid_flush";
      F_BUB:   return "idex_bubble";
      default: return "stall_cnt";
    endcase
  endfunction

  function automatic logic [15:0] dut_field(input int sel);
    case (sel)
      F_STATE: return {14'd0, state};
      F_REQ:   return {15'd0, bus.imem_req};
      F_PC:    return {15'd0, bus.pc_we};
      F_WE:    return {15'd0, bus.ifid_we};
      F_FLUSH: return {15'd0, bus.ifid_flush};
      F_BUB:   return {15'd0, bus.idex_bubble};
      default: return stall_cnt;
    endcase
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- scoreboard / model ----------------
  // The model tracks the pipeline's situation in its own terms: still booting,
  // waiting on a fetch, or how many squash cycles remain after a branch.
  typedef struct packed {
    logic [1:0] st;
    logic       req;
    logic       pc;
    logic       we;
    logic       fl;
    logic       bb;
  } exp_t;

  initial begin : compare
    bit          m_boot;
    bit          m_wait;
    int          m_squash;
    logic [15:0] m_cnt;
    bit          luh;
    exp_t        e;
    m_boot = 1; m_wait = 0; m_squash = 0; m_cnt = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        m_boot = 1; m_wait = 0; m_squash = 0; m_cnt = '0;
      end
      luh = bus.idex_mem_read && (bus.idex_rd != 0) &&
            ((bus.ifid_uses_rs && (bus.ifid_rs == bus.idex_rd)) ||
             (bus.ifid_uses_rt && (bus.ifid_rt == bus.idex_rd)));
      e = '0;
      if (m_boot) begin
        e.st = 2'd0;
      end else if (m_squash > 0) begin
        e.st = 2'd3; e.fl = 1; e.bb = 1;
      end else if (bus.branch_taken) begin
        e.st = m_wait ? 2'd2 : 2'd1; e.pc = 1; e.fl = 1; e.bb = 1;
      end else if (m_wait) begin
        e.st = 2'd2; e.req = 1;
        if (bus.imem_ack) begin e.pc = 1; e.we = 1; end
        else e.fl = 1;
      end else begin
        e.st = 2'd1; e.req = 1;
        if (luh) e.bb = 1;
        else if (!bus.imem_ack) e.fl = 1;
        else begin e.pc = 1; e.we = 1; end
      end

      check("state",       {14'd0, state},           {14'd0, e.st});
      check("imem_req",    {15'd0, bus.imem_req},    {15'd0, e.req});
      check("pc_we",       {15'd0, bus.pc_we},       {15'd0, e.pc});
      check("ifid_we",     {15'd0, bus.ifid_we},     {15'd0, e.we});
      check("ifid_flush",  {15'd0, bus.ifid_flush},  {15'd0, e.fl});
      check("idex_bubble", {15'd0, bus.idex_bubble}, {15'd0, e.bb});
      check("stall_cnt",   stall_cnt,                m_cnt);

      while (lit_idx < exp_q.size() && lit_cyc[lit_idx] <= cyc) begin
        check({"lit_", fname(lit_sel[lit_idx])}, dut_field(lit_sel[lit_idx]), exp_q[lit_idx]);
        lit_idx++;
      end

      // Advance the model to what the coming posedge produces.
      if (!rst) begin
        if (!m_boot && !e.pc && PERF != 0 && m_cnt != 16'hFFFF) m_cnt++;
        if (m_boot) m_boot = 0;
        else if (m_squash > 0) m_squash--;
        else if (bus.branch_taken) begin m_squash = FLUSH_CYCLES - 1; m_wait = 0; end
        else if (m_wait) begin if (bus.imem_ack) m_wait = 0; end
        else if (!luh && !bus.imem_ack) m_wait = 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expectation for the cycle whose inputs were just applied.
  task automatic expect_lit(input int sel, input logic [15:0] v);
    lit_cyc.push_back(cyc + 1);
    lit_sel.push_back(sel);
    exp_q.push_back(v);
  endtask

  task automatic set_luh(input bit on, input logic [5:0] rd, input bit urs, input logic [5:0] rs,
                         input bit urt, input logic [5:0] rt);
    bus.idex_mem_read = on;
    bus.idex_rd       = rd;
    bus.ifid_uses_rs  = urs;
    bus.ifid_rs       = rs;
    bus.ifid_uses_rt  = urt;
    bus.ifid_rt       = rt;
  endtask

  // ---------------- stimulus ----------------
  initial begin : driver
    rst = 1'b1;
    bus.imem_ack     = 1'b1;
    bus.branch_taken = 1'b0;
    set_luh(0, 6'd0, 0, 6'd0, 0, 6'd0);
    tick();
    tick();

    // Reset release with imem_ack tied high.
    rst = 1'b0;
    expect_lit(F_STATE, 16'd0); expect_lit(F_REQ, 16'd0); expect_lit(F_PC, 16'd0);
    tick();
    expect_lit(F_STATE, 16'd1); expect_lit(F_REQ, 16'd1); expect_lit(F_PC, 16'd1);
    expect_lit(F_WE, 16'd1); expect_lit(F_FLUSH, 16'd0); expect_lit(F_BUB, 16'd0);
    tick();
    expect_lit(F_PC, 16'd1); expect_lit(F_CNT, 16'd0);

    // Load-use on rs.
    tick();
    set_luh(1, 6'd5, 1, 6'd5, 0, 6'd0);
    expect_lit(F_PC, 16'd0); expect_lit(F_WE, 16'd0); expect_lit(F_BUB, 16'd1);
    // Same match but destination is r0: no stall.
    tick();
    set_luh(1, 6'd0, 1, 6'd0, 0, 6'd0);
    expect_lit(F_PC, 16'd1); expect_lit(F_BUB, 16'd0); expect_lit(F_CNT, 16'(PERF * 1));
    // rs matches but is not read: no stall.
    tick();
    set_luh(1, 6'd9, 0, 6'd9, 0, 6'd9);
    expect_lit(F_PC, 16'd1); expect_lit(F_BUB, 16'd0);
    // Load-use on rt.
    tick();
    set_luh(1, 6'd9, 0, 6'd9, 1, 6'd9);
    expect_lit(F_PC, 16'd0); expect_lit(F_BUB, 16'd1);
    tick();
    set_luh(0, 6'd0, 0, 6'd0, 0, 6'd0);
    expect_lit(F_PC, 16'd1); expect_lit(F_CNT, 16'(PERF * 2));

    // Fetch wait: ack low for 3 cycles.
    tick();
    bus.imem_ack = 1'b0;
    expect_lit(F_STATE, 16'd1); expect_lit(F_PC, 16'd0); expect_lit(F_FLUSH, 16'd1);
    tick();
    expect_lit(F_STATE, 16'd2); expect_lit(F_FLUSH, 16'd1); expect_lit(F_REQ, 16'd1);
    tick();
    expect_lit(F_STATE, 16'd2); expect_lit(F_FLUSH, 16'd1);
    tick();
    bus.imem_ack = 1'b1;
    expect_lit(F_STATE, 16'd2); expect_lit(F_PC, 16'd1); expect_lit(F_WE, 16'd1);
    expect_lit(F_FLUSH, 16'd0);
    tick();
    expect_lit(F_STATE, 16'd1); expect_lit(F_CNT, 16'(PERF * 5));

    // Branch in RUN together with a load-use hazard.
    tick();
    bus.branch_taken = 1'b1;
    set_luh(1, 6'd5, 1, 6'd5, 0, 6'd0);
    expect_lit(F_PC, 16'd1); expect_lit(F_FLUSH, 16'd1); expect_lit(F_BUB, 16'd1);
    expect_lit(F_REQ, 16'd0); expect_lit(F_WE, 16'd0);
    tick();
    expect_lit(F_STATE, 16'd3); expect_lit(F_PC, 16'd0); expect_lit(F_REQ, 16'd0);
    tick();
    bus.branch_taken = 1'b0;
    set_luh(0, 6'd0, 0, 6'd0, 0, 6'd0);
    expect_lit(F_STATE, 16'd3); expect_lit(F_PC, 16'd0); expect_lit(F_REQ, 16'd0);
    tick();
    expect_lit(F_STATE, 16'd1); expect_lit(F_REQ, 16'd1); expect_lit(F_CNT, 16'(PERF * 7));

    // Branch while waiting on a fetch; a late ack during FLUSH is ignored.
    tick();
    bus.imem_ack = 1'b0;
    expect_lit(F_PC, 16'd0);
    tick();
    bus.branch_taken = 1'b1;
    expect_lit(F_STATE, 16'd2); expect_lit(F_REQ, 16'd0); expect_lit(F_PC, 16'd1);
    tick();
    bus.branch_taken = 1'b0;
    bus.imem_ack = 1'b1;
    expect_lit(F_STATE, 16'd3); expect_lit(F_PC, 16'd0); expect_lit(F_WE, 16'd0);
    tick();
    expect_lit(F_STATE, 16'd3); expect_lit(F_PC, 16'd0);
    tick();
    expect_lit(F_STATE, 16'd1); expect_lit(F_PC, 16'd1); expect_lit(F_CNT, 16'(PERF * 10));

    // Async reset in the first FLUSH cycle (fcnt=1).
    tick();
    bus.branch_taken = 1'b1;
    expect_lit(F_PC, 16'd1);
    tick();
    bus.branch_taken = 1'b0;
    expect_lit(F_STATE, 16'd0); expect_lit(F_REQ, 16'd0); expect_lit(F_PC, 16'd0);
    expect_lit(F_FLUSH, 16'd0); expect_lit(F_BUB, 16'd0); expect_lit(F_CNT, 16'd0);
    #2 rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_lit(F_STATE, 16'd0); expect_lit(F_CNT, 16'd0);
    tick();
    expect_lit(F_STATE, 16'd1); expect_lit(F_PC, 16'd1); expect_lit(F_REQ, 16'd1);
    tick();
    tick();
    @(negedge clk);
    #1;

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the IF stage and the IF/ID buffer. It issues instruction-fetch requests and drives the PC write enable. It also drives the IF/ID write-enable and flush, and the ID/EX bubble, from branch, load-use and fetch-wait conditions. It sits between the PC register, instruction memory, the IF/ID buffer and the ID/EX buffer.

## Interface
- REG_ADDR_W, 6, register-specifier width (64-entry register file)
- FLUSH_CYCLES, 2, squash cycles after a taken branch; legal 1..15
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- imem_req  out  1  fetch request, level; transfer completes when imem_req and imem_ack are both high at a posedge
- imem_ack  in  1  instruction memory has valid data this cycle
- ifid_rs  in  REG_ADDR_W  rs field of the instruction in IF/ID
- ifid_rt  in  REG_ADDR_W  rt field of the instruction in IF/ID
- ifid_uses_rs  in  1  instruction in IF/ID reads rs
- ifid_uses_rt  in  1  instruction in IF/ID reads rt
- idex_mem_read  in  1  instruction in ID/EX is a load
- idex_rd  in  REG_ADDR_W  destination register of the instruction in ID/EX
- branch_taken  in  1  taken branch or jump resolved in EX this cycle
- pc_we  out  1  PC loads its next value (sequential or branch target)
- ifid_we  out  1  IF/ID captures the fetched PC and instruction
- ifid_flush  out  1  IF/ID loads a NOP; takes precedence over ifid_we
- idex_bubble  out  1  ID/EX loads a NOP in place of the decoded instruction
- state  out  2  current FSM state
- stall_cnt  out  16  stall-cycle performance counter

## Operation
- FSM states: BOOT=0, RUN=1, WAIT_MEM=2, FLUSH=3. There is also a 4-bit squash counter `fcnt`.
- Load-use hazard (`luh`) is asserted when all of the following hold:
  - idex_mem_read is 1;
  - idex_rd is not 0;
  - (ifid_uses_rs is 1 and ifid_rs equals idex_rd) or (ifid_uses_rt is 1 and ifid_rt equals idex_rd).
- BOOT:
  - All control outputs are 0.
  - Next state is RUN unconditionally.
- RUN: imem_req is 1 except where noted. Priority order:
  - branch_taken:
    - Outputs: pc_we=1, ifid_flush=1, idex_bubble=1, imem_req=0.
    - If FLUSH_CYCLES > 1: next state FLUSH, fcnt = FLUSH_CYCLES-2. Otherwise stay in RUN.
  - luh:
    - Outputs: pc_we=0, ifid_we=0, idex_bubble=1.
    - Stay in RUN.
  - imem_ack=0:
    - Outputs: pc_we=0, ifid_flush=1.
    - Next state WAIT_MEM.
  - Otherwise:
    - Outputs: pc_we=1, ifid_we=1.
    - Stay in RUN.
- WAIT_MEM: imem_req is 1. IF/ID holds a NOP, so luh is ignored.
  - branch_taken: same outputs and transition as branch_taken in RUN. Dropping imem_req abandons the outstanding fetch.
  - imem_ack=1: pc_we=1, ifid_we=1, next state RUN.
  - Otherwise: ifid_flush=1, stay in WAIT_MEM.
- FLUSH:
  - Outputs: imem_req=0, pc_we=0, ifid_flush=1, idex_bubble=1.
  - branch_taken is ignored, because only NOPs occupy EX.
  - fcnt=0: next state RUN. Otherwise decrement fcnt.
- Any output not listed for a case is 0.

## Timing
- state and fcnt are registered. All other control outputs are Mealy: combinational from state and the current inputs, valid within the same cycle.
- Reset values: state=BOOT, fcnt=0, stall_cnt=0. With state=BOOT, imem_req, pc_we, ifid_we, ifid_flush and idex_bubble are all 0.
- Reset asserted mid-operation forces BOOT immediately, regardless of any in-flight fetch or squash.
- First fetch request is issued in the 2nd cycle after reset deassertion.
- Load-use stall is exactly 1 cycle: after the stall cycle, the load has moved to EX/MEM, so luh deasserts.
- A taken branch squashes 1 + (FLUSH_CYCLES-1) cycles. The fetch at the branch target starts in the first RUN cycle after the squash.
- Simultaneous branch_taken and luh (or branch_taken and imem_ack=0): the branch wins; no stall is recorded for the luh.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cnt increments by 1 on each posedge where state is not BOOT and pc_we is 0.
  - It saturates at 16'hFFFF and clears only on rst.
- HAZARD_PERF_CNT_EN undefined: stall_cnt is constant 0 and no counter register is built.

## Test plan
- Reset release, imem_ack tied 1:
  - state goes BOOT→RUN.
  - pc_we=1 and ifid_we=1 from the 2nd cycle onward.
  - ifid_flush and idex_bubble stay 0.
- Load-use stall: idex_mem_read=1, idex_rd=5, ifid_uses_rs=1, ifid_rs=5 for 1 cycle.
  - That cycle: pc_we=0, ifid_we=0, idex_bubble=1.
  - stall_cnt increments by 1 (macro defined).
  - Repeat with idex_rd=0: no stall.
- Fetch wait: imem_ack=0 for 3 cycles, then 1.
  - RUN→WAIT_MEM; ifid_flush=1 for the 3 wait cycles.
  - On the ack cycle: pc_we=1, ifid_we=1, then RUN.
  - stall_cnt increments by 3.
- branch_taken in RUN with FLUSH_CYCLES=3 and luh also active that cycle:
  - Cycle 0: pc_we=1, ifid_flush=1, idex_bubble=1.
  - Then 2 cycles in FLUSH with pc_we=0 and imem_req=0.
  - Then RUN.
- branch_taken during WAIT_MEM:
  - imem_req drops that cycle and pc_we=1.
  - A later imem_ack arriving during FLUSH is ignored.
- Async reset during FLUSH with fcnt=1: state=BOOT and all outputs 0 before the next clk edge; stall_cnt=0.
